// File: rtl/bcd_calendar_counter.sv
// bcd_calendar_counter: free-running BCD real-time calendar.
// Advances the full date/time by one second per prescaler tick, with the
// full carry chain (leap-year aware). Supports a validated set-time load and pause.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   load                        one-cycle request to load time from load_* fields
//   load_year_bcd..load_second_bcd  BCD time to load
//   pause                       freezes prescaler and time
//   counter[63:0]               {8'h00, year, month, day, hour, minute, second}
//   sec_pulse                   strobe in the cycle after a tick advance or accepted load
//   load_ok / load_err          strobe: load accepted / rejected
module bcd_calendar_counter #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_year_bcd,
    input  logic [7:0]  load_month_bcd,
    input  logic [7:0]  load_day_bcd,
    input  logic [7:0]  load_hour_bcd,
    input  logic [7:0]  load_minute_bcd,
    input  logic [7:0]  load_second_bcd,
    input  logic        pause,
    output logic [63:0] counter,
    output logic        sec_pulse,
    output logic        load_ok,
    output logic        load_err
);

    localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : 4'(v[7:4] + 4'd1);
        end else begin
            r[3:0] = 4'(v[3:0] + 4'd1);
        end
        return r;
    endfunction

    // Two-digit BCD value divisible by 4: (10*t + o) mod 4 == (2*t + o) mod 4.
    function automatic logic bcd_div4(input logic [7:0] v);
        if (v[4])
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        else
            return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    // Leap rule: YY!=00 -> YY mod 4, century years -> CC mod 4.
    function automatic logic is_leap(input logic [15:0] year);
        if (year[7:0] != 8'h00)
            return bcd_div4(year[7:0]);
        else
            return bcd_div4(year[15:8]);
    endfunction

    // Days in month as BCD; 00 for an out-of-range month.
    function automatic logic [7:0] days_in_month(input logic [15:0] year,
                                                 input logic [7:0]  month);
        case (month)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                     return 8'h30;
            8'h02:   return is_leap(year) ? 8'h29 : 8'h28;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic bcd_ok8(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    endfunction

    logic [15:0]        year_q,   year_d;
    logic [7:0]         month_q,  month_d;
    logic [7:0]         day_q,    day_d;
    logic [7:0]         hour_q,   hour_d;
    logic [7:0]         minute_q, minute_d;
    logic [7:0]         second_q, second_d;
    logic [PRESC_W-1:0] presc_q,  presc_d;
    logic               sec_pulse_q, sec_pulse_d;
    logic               load_ok_q,   load_ok_d;
    logic               load_err_q,  load_err_d;

    logic       tick_c;
    logic       load_valid_c;
    logic [7:0] load_dim_c;
    logic [7:0] cur_dim_c;

    assign tick_c     = !pause && (presc_q == PRESC_LAST);
    assign load_dim_c = days_in_month(load_year_bcd, load_month_bcd);
    assign cur_dim_c  = days_in_month(year_q, month_q);

    // BCD comparisons are order-preserving once every nibble is a valid digit.
    assign load_valid_c = bcd_ok8(load_year_bcd[15:8]) && bcd_ok8(load_year_bcd[7:0]) &&
                          bcd_ok8(load_month_bcd) && bcd_ok8(load_day_bcd) &&
                          bcd_ok8(load_hour_bcd) && bcd_ok8(load_minute_bcd) &&
                          bcd_ok8(load_second_bcd) &&
                          (load_month_bcd >= 8'h01) && (load_month_bcd <= 8'h12) &&
                          (load_day_bcd >= 8'h01) && (load_day_bcd <= load_dim_c) &&
                          (load_hour_bcd <= 8'h23) && (load_minute_bcd <= 8'h59) &&
                          (load_second_bcd <= 8'h59);

    // Next-state: accepted load wins over a coincident tick; a rejected load does not.
    always_comb begin
        year_d      = year_q;
        month_d     = month_q;
        day_d       = day_q;
        hour_d      = hour_q;
        minute_d    = minute_q;
        second_d    = second_q;
        presc_d     = presc_q;
        sec_pulse_d = 1'b0;
        load_ok_d   = load && load_valid_c;
        load_err_d  = load && !load_valid_c;

        if (load && load_valid_c) begin
            year_d      = load_year_bcd;
            month_d     = load_month_bcd;
            day_d       = load_day_bcd;
            hour_d      = load_hour_bcd;
            minute_d    = load_minute_bcd;
            second_d    = load_second_bcd;
            presc_d     = '0;
            sec_pulse_d = 1'b1;
        end else if (tick_c) begin
            presc_d     = '0;
            sec_pulse_d = 1'b1;
            second_d    = (second_q == 8'h59) ? 8'h00 : bcd_inc2(second_q);
            if (second_q == 8'h59) begin
                minute_d = (minute_q == 8'h59) ? 8'h00 : bcd_inc2(minute_q);
                if (minute_q == 8'h59) begin
                    hour_d = (hour_q == 8'h23) ? 8'h00 : bcd_inc2(hour_q);
                    if (hour_q == 8'h23) begin
                        if (day_q == cur_dim_c) begin
                            day_d = 8'h01;
                            if (month_q == 8'h12) begin
                                month_d = 8'h01;
                                // 4-digit BCD increment, 9999 wraps to 0000.
                                if (year_q[7:0] == 8'h99)
                                    year_d = {bcd_inc2(year_q[15:8]), 8'h00};
                                else
                                    year_d = {year_q[15:8], bcd_inc2(year_q[7:0])};
                            end else begin
                                month_d = bcd_inc2(month_q);
                            end
                        end else begin
                            day_d = bcd_inc2(day_q);
                        end
                    end
                end
            end
        end else if (!pause) begin
            presc_d = PRESC_W'(presc_q + 1'b1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year_q      <= 16'h2000;
            month_q     <= 8'h01;
            day_q       <= 8'h01;
            hour_q      <= 8'h00;
            minute_q    <= 8'h00;
            second_q    <= 8'h00;
            presc_q     <= '0;
            sec_pulse_q <= 1'b0;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            presc_q     <= presc_d;
            sec_pulse_q <= sec_pulse_d;
            load_ok_q   <= load_ok_d;
            load_err_q  <= load_err_d;
        end
    end

    assign counter   = {8'h00, year_q, month_q, day_q, hour_q, minute_q, second_q};
    assign sec_pulse = sec_pulse_q;
    assign load_ok   = load_ok_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// tb_bcd_calendar_counter: directed self-checking bench for bcd_calendar_counter
// with TICK_DIV=4. Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bcd_calendar_counter;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] load_year_bcd;
    logic [7:0]  load_month_bcd;
    logic [7:0]  load_day_bcd;
    logic [7:0]  load_hour_bcd;
    logic [7:0]  load_minute_bcd;
    logic [7:0]  load_second_bcd;
    logic        pause;
    logic [63:0] counter;
    logic        sec_pulse;
    logic        load_ok;
    logic        load_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    localparam logic [63:0] RESET_VAL = 64'h0020_0001_0100_0000;

    bcd_calendar_counter #(.TICK_DIV(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (load),
        .load_year_bcd   (load_year_bcd),
        .load_month_bcd  (load_month_bcd),
        .load_day_bcd    (load_day_bcd),
        .load_hour_bcd   (load_hour_bcd),
        .load_minute_bcd (load_minute_bcd),
        .load_second_bcd (load_second_bcd),
        .pause           (pause),
        .counter         (counter),
        .sec_pulse       (sec_pulse),
        .load_ok         (load_ok),
        .load_err        (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a load for exactly one edge, then sample the strobes.
    task automatic apply_load(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                              input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        load_year_bcd   = y;
        load_month_bcd  = mo;
        load_day_bcd    = d;
        load_hour_bcd   = h;
        load_minute_bcd = mi;
        load_second_bcd = s;
        load            = 1'b1;
        step(1);
        load            = 1'b0;
    endtask

    // Valid load from a known prescaler phase, then one full tick period.
    task automatic load_and_tick(input string tag, input logic [15:0] y, input logic [7:0] mo,
                                 input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                                 input logic [7:0] s, input logic [63:0] exp_after);
        apply_load(y, mo, d, h, mi, s);
        check_eq({tag, "_ok"}, 64'(load_ok), 64'd1);
        check_eq({tag, "_loaded"}, counter, {8'h00, y, mo, d, h, mi, s});
        step(4);
        check_eq({tag, "_tick"}, counter, exp_after);
    endtask

    initial begin
        int          pulses;
        logic [63:0] held;
        logic        moved;

        rst_n = 1'b0; load = 1'b0; pause = 1'b0;
        load_year_bcd = '0; load_month_bcd = '0; load_day_bcd = '0;
        load_hour_bcd = '0; load_minute_bcd = '0; load_second_bcd = '0;

        // 1. Reset and free-running count.
        step(2);
        check_eq("rst_counter", counter, RESET_VAL);
        check_eq("rst_strobes", {61'd0, sec_pulse, load_ok, load_err}, 64'd0);
        rst_n = 1'b1;
        step(3);
        check_eq("pre_first_tick", counter, RESET_VAL);
        step(1);
        check_eq("first_tick", counter, 64'h0020_0001_0100_0001);
        check_eq("first_pulse", 64'(sec_pulse), 64'd1);
        step(1);
        check_eq("pulse_drops", 64'(sec_pulse), 64'd0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (sec_pulse) pulses++;
        end
        check_eq("pulse_rate", 64'(pulses), 64'd4);
        check_eq("after_5_ticks", counter, 64'h0020_0001_0100_0005);

        // 2. Year rollover.
        apply_load(16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
        check_eq("ny_ok", 64'(load_ok), 64'd1);
        check_eq("ny_err", 64'(load_err), 64'd0);
        check_eq("ny_pulse", 64'(sec_pulse), 64'd1);
        check_eq("ny_loaded", counter, 64'h0020_2312_3123_5959);
        step(3);
        check_eq("ny_hold", counter, 64'h0020_2312_3123_5959);
        step(1);
        check_eq("ny_tick", counter, 64'h0020_2401_0100_0000);

        // 3. Leap years.
        load_and_tick("leap2024", 16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 64'h0020_2402_2900_0000);
        load_and_tick("leap2100", 16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 64'h0021_0003_0100_0000);
        load_and_tick("leap2000", 16'h2000, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 64'h0020_0002_2900_0000);

        // 4. Invalid loads back to back from prescaler 0; the fourth lands on a tick.
        held = counter;
        apply_load(16'h2023, 8'h02, 8'h29, 8'h12, 8'h00, 8'h00);
        check_eq("bad_feb29_err", {62'd0, load_err, load_ok}, 64'd2);
        check_eq("bad_feb29_cnt", counter, held);
        apply_load(16'h2023, 8'h13, 8'h01, 8'h12, 8'h00, 8'h00);
        check_eq("bad_month_err", {62'd0, load_err, load_ok}, 64'd2);
        check_eq("bad_month_cnt", counter, held);
        apply_load(16'h2023, 8'h05, 8'h01, 8'h12, 8'h5A, 8'h00);
        check_eq("bad_min_err", {62'd0, load_err, load_ok}, 64'd2);
        check_eq("bad_min_cnt", counter, held);
        apply_load(16'h2023, 8'h05, 8'h01, 8'h24, 8'h00, 8'h00);
        check_eq("bad_hour_err", {62'd0, load_err, load_ok}, 64'd2);
        check_eq("bad_hour_tick", counter, 64'h0020_0002_2900_0001);
        check_eq("bad_hour_pulse", 64'(sec_pulse), 64'd1);

        // 5. Accepted load in the tick cycle drops that tick.
        step(3);
        check_eq("pre_collide", counter, 64'h0020_0002_2900_0001);
        apply_load(16'h2024, 8'h06, 8'h15, 8'h12, 8'h34, 8'h56);
        check_eq("collide_ok", 64'(load_ok), 64'd1);
        check_eq("collide_val", counter, 64'h0020_2406_1512_3456);
        step(3);
        check_eq("collide_hold", counter, 64'h0020_2406_1512_3456);
        step(1);
        check_eq("collide_next", counter, 64'h0020_2406_1512_3457);

        // 6. Full wrap, pause, load while paused, reset while paused.
        load_and_tick("wrap", 16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 64'h0000_0001_0100_0000);
        step(1);
        pause = 1'b1;
        held  = counter;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sec_pulse || counter !== held) moved = 1'b1;
        end
        check_eq("pause_frozen", 64'(moved), 64'd0);
        check_eq("pause_value", counter, 64'h0000_0001_0100_0000);
        apply_load(16'h2022, 8'h01, 8'h01, 8'h10, 8'h00, 8'h00);
        check_eq("pause_load_ok", 64'(load_ok), 64'd1);
        step(8);
        check_eq("pause_load_held", counter, 64'h0020_2201_0110_0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", counter, RESET_VAL);
        check_eq("async_rst_strobes", {61'd0, sec_pulse, load_ok, load_err}, 64'd0);
        step(1);
        pause = 1'b0;
        rst_n = 1'b1;
        step(4);
        check_eq("post_rst_tick", counter, 64'h0020_0001_0100_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_calendar_counter.md
Name: bcd_calendar_counter

Overview:
- Free-running BCD real-time calendar. It produces the packed 64-bit `counter` time bus that the alarm block compares against.
- The block sits between the clock prescaler domain and all time consumers (alarm, display).
- It supports a validated load (set-time) and a pause control.
- All time fields are advanced in one cycle per one-second tick, with the full carry chain.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per second tick. Must be ≥2. Benches use 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle request to load the time from the load_* fields.
- load_year_bcd  input  16  BCD year, 4 digits.
- load_month_bcd  input  8  BCD month.
- load_day_bcd  input  8  BCD day.
- load_hour_bcd  input  8  BCD hour.
- load_minute_bcd  input  8  BCD minute.
- load_second_bcd  input  8  BCD second.
- pause  input  1  when 1, the prescaler and the time hold.
- counter  output  64  packed time bus (layout below).
- sec_pulse  output  1  one-cycle strobe, high in the cycle after each tick advance.
- load_ok  output  1  one-cycle strobe: load accepted.
- load_err  output  1  one-cycle strobe: load rejected.

Behaviour:
- Counter layout:
  - [63:56] = 8'h00
  - [55:40] = year
  - [39:32] = month
  - [31:24] = day
  - [23:16] = hour
  - [15:8] = minute
  - [7:0] = second
- Reset values (async, rst_n=0):
  - counter = 64'h0020_0001_0100_0000 (2000-01-01 00:00:00)
  - prescaler = 0
  - sec_pulse = 0, load_ok = 0, load_err = 0
- Prescaler:
  - Counts 0..TICK_DIV-1 while pause=0; holds while pause=1.
  - A tick occurs in a cycle where prescaler==TICK_DIV-1 and pause=0; the prescaler then returns to 0.
- Tick advance (registered at the same edge as the tick):
  - second increments.
  - 59→00 carries to minute; minute 59→00 carries to hour; hour 23→00 carries to day.
  - day==days_in_month → 01, carry to month; month 12→01, carry to year.
  - year 9999→0000.
  - Every digit stays valid BCD; no binary intermediate is exposed.
- sec_pulse: registered; =1 exactly in the cycle after a tick edge or an accepted load, else 0.
- days_in_month:
  - 31 for months 01,03,05,07,08,10,12.
  - 30 for months 04,06,09,11.
  - For 02: 29 if leap, else 28.
- Leap rule, with YY = low two digits and CC = high two digits:
  - If YY≠00: leap iff YY mod 4==0.
  - If YY==00: leap iff CC mod 4==0.
- Load validation (combinational, on the load_* inputs) passes only if:
  - every nibble ≤9;
  - month 01..12;
  - day 01..days_in_month(load year, load month);
  - hour ≤23, minute ≤59, second ≤59.
- Load accepted (load=1 and valid), at the next edge:
  - counter = loaded fields, prescaler = 0, load_ok = 1 for 1 cycle.
- Load rejected (load=1 and invalid):
  - counter and prescaler unchanged; load_err = 1 for 1 cycle.
- Simultaneous load and tick:
  - An accepted load wins; that tick is dropped.
  - A rejected load does not suppress the tick.
- Load while pause=1 is permitted. Time stays frozen at the loaded value.
- load held high on consecutive cycles: each cycle is evaluated independently.
- Reset asserted mid-operation: all state returns to the reset values immediately (async). Counting resumes from prescaler 0 after deassertion.

Test Plan:
1. Reset, then release with pause=0, TICK_DIV=4:
   - counter=64'h0020_0001_0100_0000 during reset.
   - After 4 cycles it reads 64'h0020_0001_0100_0001.
   - sec_pulse is high once per 4 cycles.
2. Load 2023-12-31 23:59:59:
   - load_ok=1 and counter=64'h0020_2312_3123_5959.
   - After one tick, counter=64'h0020_2401_0100_0000.
3. Leap years: load each date and apply one tick.
   - 2024-02-28 23:59:59 → 2024-02-29 00:00:00.
   - 2100-02-28 23:59:59 → 2100-03-01 00:00:00.
   - 2000-02-28 23:59:59 → 2000-02-29 00:00:00.
4. Invalid loads: 2023-02-29, month 8'h13, minute 8'h5A, hour 8'h24.
   - load_err=1 each time; load_ok=0.
   - counter unchanged and continues ticking normally.
5. Load asserted in the tick cycle (prescaler==3):
   - counter equals the loaded value with no +1 second.
   - Next increment occurs 4 cycles later.
6. Wrap and pause:
   - 9999-12-31 23:59:59 + tick → 64'h0000_0001_0100_0000.
   - pause=1 for 20 cycles: counter and sec_pulse frozen.
   - Assert rst_n=0 mid-pause: immediate reset value.
